// File: rtl/hour12_counter_pkg.sv
// Shared clock-domain definitions: BCD hour constants, hour state type and
// the BCD helpers used by the hour counter and the alarm compare logic.
package clock_pkg;

   localparam int             BCD_W      = 4;
   localparam logic [7:0]     HOUR12_MIN = 8'h01;
   localparam logic [7:0]     HOUR12_MAX = 8'h12;
   localparam logic [7:0]     HOUR12_PRE = 8'h11;
   localparam logic [7:0]     HOUR24_MAX = 8'h23;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_LOAD,
      ACT_SET,
      ACT_CARRY
   } hour_act_e;

   typedef struct packed {
      logic [7:0] bcd;
      logic       pm;
   } hour12_t;

   localparam hour12_t HOUR_RESET = '{bcd: HOUR12_MAX, pm: 1'b0};

   // BCD 01..11 plus twelve, giving 13..23.
   function automatic logic [7:0] bcd_add12(input logic [7:0] h);
      logic [BCD_W-1:0] u;
      logic [BCD_W-1:0] t;
      u = h[3:0] + 4'd2;
      t = h[7:4] + 4'd1;
      if (u > 4'd9) begin
         u = u - 4'd10;
         t = t + 4'd1;
      end
      return {t, u};
   endfunction

   // BCD 13..23 minus twelve, giving 01..11.
   function automatic logic [7:0] bcd_sub12(input logic [7:0] h);
      logic [BCD_W-1:0] u;
      logic [BCD_W-1:0] t;
      if (h[3:0] < 4'd2) begin
         u = h[3:0] + 4'd8;
         t = h[7:4] - 4'd2;
      end else begin
         u = h[3:0] - 4'd2;
         t = h[7:4] - 4'd1;
      end
      return {t, u};
   endfunction

   // Next 12-hour BCD value in the sequence 12,01,...,11,12.
   function automatic logic [7:0] hour12_inc(input logic [7:0] h);
      logic [7:0] r;
      if (h == HOUR12_MAX)
         r = HOUR12_MIN;
      else if (h[3:0] == 4'd9)
         r = {h[7:4] + 4'd1, 4'd0};
      else
         r = {h[7:4], h[3:0] + 4'd1};
      return r;
   endfunction

   // Advance the full 12h+pm state; pm flips on the 11 -> 12 step.
   function automatic hour12_t hour_step(input hour12_t s);
      hour12_t r;
      r.bcd = hour12_inc(s.bcd);
      r.pm  = s.pm ^ (s.bcd == HOUR12_PRE);
      return r;
   endfunction

   // Digits must be decimal and the value must not exceed 23 (BCD compare
   // is ordered once both digits are known to be 0..9).
   function automatic logic load_valid(input logic [3:0] ch, input logic [3:0] cl);
      return (ch <= 4'd9) && (cl <= 4'd9) && ({ch, cl} <= HOUR24_MAX);
   endfunction

   function automatic hour12_t load_to_hour12(input logic [3:0] ch, input logic [3:0] cl);
      hour12_t    r;
      logic [7:0] v;
      v    = {ch, cl};
      r.pm = (v >= HOUR12_MAX);
      if (v == 8'h00)
         r.bcd = HOUR12_MAX;
      else if (v <= HOUR12_MAX)
         r.bcd = v;
      else
         r.bcd = bcd_sub12(v);
      return r;
   endfunction

endpackage

// File: rtl/hour12_counter_conv.sv
// Combinational 12-hour BCD + AM/PM to 24-hour BCD converter.
module hour12_to_24_conv
   import clock_pkg::*;
(
   input  logic [7:0] i_h12,
   input  logic       i_pm,
   output logic [7:0] o_h24
);

   always_comb begin
      o_h24 = i_h12;
      if (i_h12 == HOUR12_MAX)
         o_h24 = i_pm ? HOUR12_MAX : 8'h00;
      else if (i_pm)
         o_h24 = bcd_add12(i_h12);
   end

endmodule

// File: rtl/hour12_counter.sv
// 12-hour BCD hour counter with AM/PM, 24-hour shadow output, set-mode
// buttons and a validated 24-hour preset load.
module hour12_counter
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       carry_in,
   input  logic       set_mode,
   input  logic       inc_set,
   input  logic       pm_toggle,
   input  logic       load,
   input  logic [3:0] load_CH,
   input  logic [3:0] load_CL,
   output logic [3:0] H12_CH,
   output logic [3:0] H12_CL,
   output logic       pm,
   output logic [3:0] H24_CH,
   output logic [3:0] H24_CL,
   output logic       day_carry,
   output logic       load_err
);

   hour12_t   r_hour;
   logic [7:0] r_h24;
   logic      r_day_carry;
   logic      r_load_err;

   hour_act_e w_act;
   hour12_t   w_nxt_hour;
   logic [7:0] w_nxt_h24;
   logic      w_nxt_day_carry;
   logic      w_nxt_load_err;

   always_comb begin
      if (load)
         w_act = ACT_LOAD;
      else if (set_mode)
         w_act = ACT_SET;
      else if (carry_in)
         w_act = ACT_CARRY;
      else
         w_act = ACT_NONE;
   end

   always_comb begin
      w_nxt_hour      = r_hour;
      w_nxt_day_carry = 1'b0;
      w_nxt_load_err  = 1'b0;
      case (w_act)
         ACT_LOAD: begin
            if (load_valid(load_CH, load_CL))
               w_nxt_hour = load_to_hour12(load_CH, load_CL);
            else
               w_nxt_load_err = 1'b1;
         end
         // inc_set wins over pm_toggle; set-mode steps never end the day
         ACT_SET: begin
            if (inc_set)
               w_nxt_hour = hour_step(r_hour);
            else if (pm_toggle)
               w_nxt_hour.pm = ~r_hour.pm;
         end
         ACT_CARRY: begin
            w_nxt_hour      = hour_step(r_hour);
            w_nxt_day_carry = r_hour.pm && (r_hour.bcd == HOUR12_PRE);
         end
         default: ;
      endcase
   end

   hour12_to_24_conv u_conv (
      .i_h12 (w_nxt_hour.bcd),
      .i_pm  (w_nxt_hour.pm),
      .o_h24 (w_nxt_h24)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hour      <= HOUR_RESET;
         r_h24       <= 8'h00;
         r_day_carry <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_hour      <= w_nxt_hour;
         r_h24       <= w_nxt_h24;
         r_day_carry <= w_nxt_day_carry;
         r_load_err  <= w_nxt_load_err;
      end
   end

   assign H12_CH    = r_hour.bcd[7:4];
   assign H12_CL    = r_hour.bcd[3:0];
   assign pm        = r_hour.pm;
   assign H24_CH    = r_h24[7:4];
   assign H24_CL    = r_h24[3:0];
   assign day_carry = r_day_carry;
   assign load_err  = r_load_err;

endmodule

// File: tb/tb_hour12_counter.sv
// Bench for hour12_counter: hour-of-day integer model, per-cycle compare,
// directed literal checks and randomized stimulus.
module tb_hour12_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       carry_in = 1'b0;
   logic       set_mode = 1'b0;
   logic       inc_set = 1'b0;
   logic       pm_toggle = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_CH = 4'd0;
   logic [3:0] load_CL = 4'd0;
   logic [3:0] H12_CH, H12_CL, H24_CH, H24_CL;
   logic       pm, day_carry, load_err;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // model: hour of day 0..23, plus the two pulse flags
   int m_h = 0;
   bit m_dc = 1'b0;
   bit m_le = 1'b0;

   hour12_counter dut (
      .clk       (clk),
      .rst       (rst),
      .carry_in  (carry_in),
      .set_mode  (set_mode),
      .inc_set   (inc_set),
      .pm_toggle (pm_toggle),
      .load      (load),
      .load_CH   (load_CH),
      .load_CL   (load_CL),
      .H12_CH    (H12_CH),
      .H12_CL    (H12_CL),
      .pm        (pm),
      .H24_CH    (H24_CH),
      .H24_CL    (H24_CL),
      .day_carry (day_carry),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [21:0] model_outs(input int h, input bit dc, input bit le);
      int h12;
      h12 = (h % 12 == 0) ? 12 : h % 12;
      return {to_bcd(h12), (h >= 12) ? 1'b1 : 1'b0, to_bcd(h), dc, le};
   endfunction

   always @(posedge clk) begin
      int v;
      if (rst) begin
         m_h  <= 0;
         m_dc <= 1'b0;
         m_le <= 1'b0;
      end else begin
         m_dc <= 1'b0;
         m_le <= 1'b0;
         if (load) begin
            v = int'(load_CH) * 10 + int'(load_CL);
            if (load_CH <= 2 && load_CL <= 9 && v <= 23)
               m_h <= v;
            else
               m_le <= 1'b1;
         end else if (set_mode) begin
            if (inc_set)
               m_h <= (m_h + 1) % 24;
            else if (pm_toggle)
               m_h <= (m_h + 12) % 24;
         end else if (carry_in) begin
            m_dc <= (m_h == 23);
            m_h  <= (m_h + 1) % 24;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en)
         chk("cycle", {10'd0, H12_CH, H12_CL, pm, H24_CH, H24_CL, day_carry, load_err},
             {10'd0, model_outs(m_h, m_dc, m_le)});
   end

   task automatic cyc(input bit r, input bit c, input bit sm, input bit inc, input bit pt,
                      input bit ld, input logic [3:0] ch, input logic [3:0] cl);
      rst = r; carry_in = c; set_mode = sm; inc_set = inc; pm_toggle = pt;
      load = ld; load_CH = ch; load_CL = cl;
      @(posedge clk);
      #1;
      rst = 1'b0; carry_in = 1'b0; inc_set = 1'b0; pm_toggle = 1'b0; load = 1'b0;
      @(negedge clk);
      #2;
   endtask

   task automatic chk_state(input string name, input logic [7:0] h12, input bit p,
                            input logic [7:0] h24, input bit dc, input bit le);
      chk(name, {H12_CH, H12_CL, pm, H24_CH, H24_CL, day_carry, load_err},
          {h12, p, h24, dc, le});
   endtask

   initial begin
      int dc_count;
      @(negedge clk);
      #2;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 1, 4'h1, 4'h5);
      chk_en = 1'b1;
      chk_state("reset", 8'h12, 0, 8'h00, 0, 0);

      // full day of carries
      dc_count = 0;
      for (int i = 1; i <= 24; i++) begin
         cyc(0, 1, 0, 0, 0, 0, 0, 0);
         chk("day_h24", {H24_CH, H24_CL}, to_bcd(i % 24));
         if (day_carry) dc_count++;
         if (i == 12) chk_state("noon", 8'h12, 1, 8'h12, 0, 0);
         if (i == 24) chk("day_carry_last", day_carry, 1);
      end
      chk("day_carry_count", dc_count, 1);

      cyc(0, 0, 0, 0, 0, 1, 4'h2, 4'h3);
      chk_state("load23", 8'h11, 1, 8'h23, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      chk_state("load23_carry", 8'h12, 0, 8'h00, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
      chk_state("load00", 8'h12, 0, 8'h00, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 4'h1, 4'h2);
      chk_state("load12", 8'h12, 1, 8'h12, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 4'h2, 4'h4);
      chk_state("load24_err", 8'h12, 1, 8'h12, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 4'h0, 4'hA);
      chk_state("load0A_err", 8'h12, 1, 8'h12, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 4'h0, 4'h9);
      chk_state("load09", 8'h09, 0, 8'h09, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 4'h2, 4'h1);
      chk_state("load21", 8'h09, 1, 8'h21, 0, 0);

      // set mode from 11 AM
      cyc(0, 0, 0, 0, 0, 1, 4'h1, 4'h1);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      chk_state("set_carry_frozen", 8'h11, 0, 8'h11, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      chk_state("set_inc_noon", 8'h12, 1, 8'h12, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 0, 0);
      chk_state("set_pm_toggle", 8'h12, 0, 8'h00, 0, 0);
      cyc(0, 0, 1, 1, 1, 0, 0, 0);
      chk_state("set_inc_wins", 8'h01, 0, 8'h01, 0, 0);
      cyc(0, 0, 1, 0, 0, 1, 4'h2, 4'h3);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      chk_state("set_inc_midnight", 8'h12, 0, 8'h00, 0, 0);

      // priority
      cyc(0, 1, 0, 0, 0, 1, 4'h1, 4'h5);
      chk_state("load_over_carry", 8'h03, 1, 8'h15, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 4'h1, 4'h5);
      chk_state("rst_over_load", 8'h12, 0, 8'h00, 0, 0);

      // back-to-back held carry
      carry_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 carry_in = 1'b0;
      @(negedge clk);
      #2;
      chk_state("held_carry", 8'h03, 0, 8'h03, 0, 0);

      // randomized
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] ch, cl;
         if ($urandom_range(0, 3) == 0) begin
            ch = 4'($urandom_range(0, 15));
            cl = 4'($urandom_range(0, 15));
         end else begin
            ch = 4'($urandom_range(0, 2));
            cl = 4'($urandom_range(0, 9));
         end
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0,
             ch, cl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
